// File: rtl/masked_sub3_scheduler.sv
// Round-robin issue scheduler for a shared, pipelined masked 3-bit subtractor.
// Tracks in-flight operations with a tag pipeline and buffers results in a credit-protected FIFO.
module masked_sub3_scheduler #(
    parameter int D     = 2,
    parameter int LAT   = 6,
    parameter int DEPTH = 8,
    parameter int RW    = 7 * D * (D - 1) / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3*D-1:0]    req0_a,
    input  logic [3*D-1:0]    req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3*D-1:0]    req1_a,
    input  logic [3*D-1:0]    req1_b,
    input  logic              prng_valid,
    output logic              prng_ready,
    input  logic [RW-1:0]     prng_rnd,
    output logic [3*D-1:0]    sub_a,
    output logic [3*D-1:0]    sub_b,
    output logic [RW-1:0]     sub_rnd,
    output logic              sub_issue,
    input  logic [4*D-1:0]    sub_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4*D-1:0]    res_data,
    output logic              res_src,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 2);
    localparam int SW = $clog2(LAT + DEPTH + 3);

    logic            issue;
    logic            grant1;
    logic            last_grant;
    logic            credit_ok;
    logic            sub_src;
    logic [LAT:1]    tag_v;
    logic [LAT:1]    tag_src;
    logic [IW-1:0]   inflight;
    logic [OW-1:0]   occ;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [4*D-1:0]  mem_data [DEPTH];
    logic [DEPTH-1:0] mem_src;
    logic            push;
    logic            pop;

    // The launch register is counted as in flight too: an op sitting on sub_issue
    // has not reached the tag pipeline yet but already owns a FIFO slot.
    always_comb begin
        inflight = IW'(sub_issue);
        for (int i = 1; i <= LAT; i++) begin
            inflight = inflight + IW'(tag_v[i]);
        end
    end

    assign push = tag_v[LAT];
    assign pop  = res_valid & res_ready;

    // A pop on this edge frees a slot for the op issued on the same edge.
    assign credit_ok = (SW'(inflight) + SW'(occ)) < (SW'(DEPTH) + SW'(pop));
    assign grant1    = req1_valid & (~req0_valid | ~last_grant);
    assign issue     = rst_n & (req0_valid | req1_valid) & prng_valid & credit_ok;

    assign req0_ready = issue & ~grant1;
    assign req1_ready = issue & grant1;
    assign prng_ready = issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_issue  <= 1'b0;
            sub_src    <= 1'b0;
            sub_a      <= '0;
            sub_b      <= '0;
            sub_rnd    <= '0;
            last_grant <= 1'b1;
        end else begin
            sub_issue <= issue;
            sub_src   <= issue & grant1;
            sub_a     <= issue ? (grant1 ? req1_a : req0_a) : '0;
            sub_b     <= issue ? (grant1 ? req1_b : req0_b) : '0;
            sub_rnd   <= issue ? prng_rnd : '0;
            if (issue) begin
                last_grant <= grant1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v   <= '0;
            tag_src <= '0;
        end else begin
            tag_v[1]   <= sub_issue;
            tag_src[1] <= sub_src;
            for (int i = 2; i <= LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_src[i] <= tag_src[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sub_out;
            mem_src[wr_ptr]  <= tag_src[LAT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign res_valid = (occ != '0);
    assign res_data  = res_valid ? mem_data[rd_ptr] : '0;
    assign res_src   = res_valid & mem_src[rd_ptr];
    assign busy      = (inflight != '0) | (occ != '0);

endmodule

// File: tb/tb_masked_sub3_scheduler.sv
// Directed bench for masked_sub3_scheduler with a masked subtractor model and result scoreboard.
module tb_masked_sub3_scheduler;

    localparam int D     = 2;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam int RW    = 7 * D * (D - 1) / 2;

    typedef struct packed {
        logic [2:0]     a;
        logic [2:0]     b;
        logic [3*D-1:0] ma;
        logic [3*D-1:0] mb;
    } op_t;

    typedef struct packed {
        logic       src;
        logic [3:0] val;
    } exp_t;

    logic clk, rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3*D-1:0] req0_a, req0_b, req1_a, req1_b;
    logic prng_valid, prng_ready;
    logic [RW-1:0] prng_rnd;
    logic [3*D-1:0] sub_a, sub_b;
    logic [RW-1:0] sub_rnd;
    logic sub_issue;
    logic [4*D-1:0] sub_out;
    logic res_valid, res_ready, res_src, busy;
    logic [4*D-1:0] res_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_issue = 0;
    int n_acc = 0;
    int n_res = 0;
    logic acc0 = 0, acc1 = 0, took_rnd = 0;
    logic [RW-1:0] rnd_ctr = 1;

    op_t pend0[$];
    op_t pend1[$];
    op_t op_q[$];
    exp_t sb_q[$];
    logic [RW-1:0] rnd_q[$];
    int grant_log[$];
    int grant_cyc[$];

    masked_sub3_scheduler #(.D(D), .LAT(LAT), .DEPTH(DEPTH), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .prng_valid(prng_valid), .prng_ready(prng_ready), .prng_rnd(prng_rnd),
        .sub_a(sub_a), .sub_b(sub_b), .sub_rnd(sub_rnd), .sub_issue(sub_issue),
        .sub_out(sub_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_src(res_src),
        .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3*D-1:0] mask3(input logic [2:0] v);
        logic [3*D-1:0] m = '0;
        logic s;
        for (int i = 0; i < 3; i++) begin
            s = v[i];
            for (int j = 0; j < D - 1; j++) begin
                m[D*i+j] = 1'($urandom);
                s = s ^ m[D*i+j];
            end
            m[D*i+D-1] = s;
        end
        return m;
    endfunction

    function automatic logic [2:0] unmask3(input logic [3*D-1:0] x);
        logic [2:0] r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < D; j++) r[i] = r[i] ^ x[D*i+j];
        return r;
    endfunction

    function automatic logic [3:0] unmask4(input logic [4*D-1:0] x);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < D; j++) r[i] = r[i] ^ x[D*i+j];
        return r;
    endfunction

    function automatic logic [4*D-1:0] remask4(input logic [3:0] c, input logic [RW-1:0] rnd);
        logic [4*D-1:0] m = '0;
        logic s;
        for (int i = 0; i < 4; i++) begin
            s = c[i];
            for (int j = 0; j < D - 1; j++) begin
                m[D*i+j] = rnd[(i*(D-1)+j) % RW];
                s = s ^ m[D*i+j];
            end
            m[D*i+D-1] = s;
        end
        return m;
    endfunction

    // Masked subtractor model: LAT-cycle pipeline fed from the launch registers.
    logic [4*D-1:0] pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= remask4({1'b0, unmask3(sub_a)} - {1'b0, unmask3(sub_b)}, sub_rnd);
    end
    assign sub_out = pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic push_op(input logic src, input logic [2:0] a, input logic [2:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        o.ma = mask3(a);
        o.mb = mask3(b);
        if (src) pend1.push_back(o);
        else pend0.push_back(o);
    endtask

    task automatic accept(input logic src);
        op_t o;
        exp_t e;
        chk("accept_has_pending", src ? (pend1.size() != 0) : (pend0.size() != 0), 1);
        if (src ? (pend1.size() != 0) : (pend0.size() != 0)) begin
            o = src ? pend1[0] : pend0[0];
            e.src = src;
            e.val = {1'b0, o.a} - {1'b0, o.b};
            sb_q.push_back(e);
            op_q.push_back(o);
            grant_log.push_back(int'(src));
            grant_cyc.push_back(cyc);
            n_acc++;
        end
    endtask

    task automatic flush();
        pend0.delete(); pend1.delete(); op_q.delete(); sb_q.delete(); rnd_q.delete();
        acc0 = 0; acc1 = 0; took_rnd = 0;
        n_acc = n_res;
    endtask

    // Requester / PRNG driver: advances to the next operand after acceptance.
    always @(posedge clk) begin
        #1;
        if (acc0 && pend0.size() != 0) void'(pend0.pop_front());
        if (acc1 && pend1.size() != 0) void'(pend1.pop_front());
        if (took_rnd) begin
            rnd_ctr = rnd_ctr + 1'b1;
            if (rnd_ctr == '0) rnd_ctr = 1;
        end
        acc0 = 0; acc1 = 0; took_rnd = 0;
        req0_valid = (pend0.size() != 0);
        req0_a = req0_valid ? pend0[0].ma : '0;
        req0_b = req0_valid ? pend0[0].mb : '0;
        req1_valid = (pend1.size() != 0);
        req1_a = req1_valid ? pend1[0].ma : '0;
        req1_b = req1_valid ? pend1[0].mb : '0;
        prng_rnd = rnd_ctr;
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        op_t o;
        exp_t e;
        if (rst_n) begin
            if (sub_issue) begin
                n_issue++;
                chk("issue_has_op", op_q.size() != 0, 1);
                if (op_q.size() != 0) begin
                    o = op_q.pop_front();
                    chk("sub_a", sub_a, o.ma);
                    chk("sub_b", sub_b, o.mb);
                end
                chk("issue_has_rnd", rnd_q.size() != 0, 1);
                if (rnd_q.size() != 0) chk("sub_rnd", sub_rnd, rnd_q.pop_front());
            end else begin
                chk("idle_launch_zero", {sub_a, sub_b, sub_rnd}, 0);
            end
            chk("ready_exclusive", req0_ready & req1_ready, 0);
            chk("prng_ready_eq_issue", prng_ready, req0_ready | req1_ready);
            if (req0_ready) accept(1'b0);
            if (req1_ready) accept(1'b1);
            if (prng_ready) rnd_q.push_back(prng_rnd);
            acc0 = req0_ready; acc1 = req1_ready; took_rnd = prng_ready;
            if (res_valid && res_ready) begin
                n_res++;
                chk("res_has_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("res_data", unmask4(res_data), e.val);
                    chk("res_src", res_src, e.src);
                end
            end
            chk("no_overflow", (n_acc - n_res) <= DEPTH, 1);
        end
    end

    task automatic hard_reset();
        #1 rst_n = 0;
        #1 flush();
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((pend0.size() != 0 || pend1.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, k < budget, 1);
    endtask

    task automatic single_op(input string tag, input logic src, input logic [2:0] a,
                             input logic [2:0] b, input logic [3:0] want);
        int k = 0;
        int n = 0;
        @(negedge clk);
        push_op(src, a, b);
        while (!(src ? req1_ready : req0_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_granted"}, k < 20, 1);
        @(negedge clk);
        chk({tag, "_ready_pulse"}, src ? req1_ready : req0_ready, 0);
        chk({tag, "_sub_issue"}, sub_issue, 1);
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, LAT + 1);
        chk({tag, "_value"}, unmask4(res_data), want);
        chk({tag, "_src"}, res_src, src);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_issue, base_res, k;
        rst_n = 1;
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;
        prng_valid = 0; prng_rnd = '0; res_ready = 0;
        #1 rst_n = 0;
        #2;
        chk("reset_ctl", {req0_ready, req1_ready, prng_ready, sub_issue, res_valid, res_src, busy}, 0);
        chk("reset_data", {sub_a, sub_b, sub_rnd, res_data}, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        prng_valid = 1;
        res_ready = 1;

        single_op("sub_5_3", 1'b0, 3'd5, 3'd3, 4'b0010);
        single_op("sub_2_6", 1'b1, 3'd2, 3'd6, 4'b1100);
        single_op("sub_0_7", 1'b1, 3'd0, 3'd7, 4'b1001);
        wait_idle("single_drain", 50);

        // Contention: both requesters streaming, grants alternate from requester 0.
        hard_reset();
        grant_log.delete(); grant_cyc.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            push_op(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            push_op(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        wait_idle("contention_drain", 100);
        chk("contention_grants", grant_log.size(), 12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++) chk("contention_order", grant_log[i], i % 2);
        if (grant_cyc.size() == 12) chk("contention_rate", grant_cyc[11] - grant_cyc[0], 11);
        chk("contention_all_results", sb_q.size(), 0);

        // Backpressure: FIFO credit limits outstanding ops to DEPTH.
        @(posedge clk); #1 res_ready = 0;
        base_issue = n_issue;
        base_res = n_res;
        @(negedge clk);
        for (int i = 0; i < 12; i++) push_op(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        repeat (20) @(negedge clk);
        chk("bp_issue_count", n_issue - base_issue, DEPTH);
        chk("bp_ready_held", req0_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_busy", busy, 1);
        @(posedge clk); #1 res_ready = 1;
        wait_idle("bp_drain", 200);
        chk("bp_total_issues", n_issue - base_issue, 12);
        chk("bp_total_results", n_res - base_res, 12);
        chk("bp_scoreboard_empty", sb_q.size(), 0);

        // PRNG starvation mid-stream.
        @(negedge clk);
        for (int i = 0; i < 10; i++) push_op(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        repeat (3) @(negedge clk);
        @(posedge clk); #1 prng_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("starve_req_ready", req0_ready, 0);
            chk("starve_prng_ready", prng_ready, 0);
            if (i > 0) chk("starve_sub", {sub_issue, sub_a, sub_b, sub_rnd}, 0);
        end
        @(posedge clk); #1 prng_valid = 1;
        wait_idle("starve_drain", 100);
        chk("starve_rnd_all_used", rnd_q.size(), 0);
        chk("starve_scoreboard_empty", sb_q.size(), 0);

        // Reset with ops both in flight and buffered.
        @(posedge clk); #1 res_ready = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) push_op(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        k = 0;
        while (!res_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_first_result", k < 30, 1);
        @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("midrst_ctl", {req0_ready, req1_ready, prng_ready, sub_issue, res_valid, res_src, busy}, 0);
        chk("midrst_data", {sub_a, sub_b, sub_rnd, res_data}, 0);
        flush();
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1 res_ready = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", {res_valid, busy}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
